iob_ram_tdp_be_sync: RTL and testbench
======================================

Name: iob_ram_tdp_be_sync

Overview:
True dual-port RAM with per-byte write enables: two independent read/write ports (A and B) share one storage array of 2**ADDR_W words of DATA_W bits. Both ports run on a single common clock. Read data is registered and synchronously resettable. It serves as a generic on-chip buffer or shared memory between two masters in a single clock domain.

Parameters:
DATA_W, 32, word width in bits; must be a multiple of 8.
ADDR_W, 4, address width; depth = 2**ADDR_W words.

Ports:
clk  input  1  system clock; all activity on rising edge.
rst  input  1  synchronous, active-high reset.
enA  input  1  port A access enable.
weA  input  DATA_W/8  port A byte write enables; bit k covers din bits [8k+7:8k].
addrA  input  ADDR_W  port A word address.
dinA  input  DATA_W  port A write data.
doutA  output  DATA_W  port A registered read data.
enB  input  1  port B access enable.
weB  input  DATA_W/8  port B byte write enables.
addrB  input  ADDR_W  port B word address.
dinB  input  DATA_W  port B write data.
doutB  output  DATA_W  port B registered read data.

Behaviour:
- Reset: rst=1 at a rising edge sets doutA=0 and doutB=0. Reset overrides enA/enB; no writes occur on that edge. Memory contents are not cleared; power-up contents are undefined.
- Port access, per port (A shown; B identical): on a rising edge with rst=0 and enA=1:
  - For each k with weA[k]=1, byte k of mem[addrA] takes dinA byte k. Bytes with weA[k]=0 are untouched.
  - doutA takes mem[addrA] as it was before this edge (read-first). Read latency is 1 cycle: address applied before edge N, data valid after edge N.
- enA=0: no write regardless of weA. doutA holds its previous value.
- weA=0 with enA=1: pure read.
- Cross-port, same address, same edge:
  - A writing and B reading: B returns the old data.
  - Both writing the same byte lane: port A's byte wins.
  - Different byte lanes: both writes take effect (byte merge).
- Different addresses: ports are fully independent. A write by one port is visible to the other from the next edge on.
- Address range is 0..2**ADDR_W-1 exactly; no wrap logic is needed beyond natural truncation.
- X/unknown on weA/weB bits while en=0 must not corrupt memory.

Test Plan:
- Reset: drive arbitrary dout state, assert rst one cycle with enA=enB=1, weA=weB=all-ones -> doutA=doutB=0, memory unchanged (subsequent read of a previously written addr returns the old value).
- Port A fill/readback: enA=1, weA=4'hF, write addr i with 32+i for i=0..15. Then weA=0, read addr i -> doutA=32+i one cycle after the address is applied.
- Port B overwrite, cross visibility: enB=1, weB=4'hF, write addr i with 64+i. Read via B -> 64+i. Read via A -> 64+i, and never 32+i.
- Byte enables: write 0xAABBCCDD to addr 3 (we=4'hF), then write 0x11223344 with we=4'b0010 -> read returns 0xAABB33DD. Then we=4'b1001 with 0x55667788 -> 0x55BB3388.
- Read-first and collision: mem[5]=0x0; A writes 0x12345678 to addr 5 while B reads addr 5 -> doutB=0x0 and doutA=0x0 that cycle; next read returns 0x12345678. Both ports write addr 6 (A=0x1, B=0x2, we=4'hF) -> mem[6]=0x1.
- Enable gating: with enA=0, weA=4'hF, dinA=0xDEADBEEF at addr 2 -> mem[2] unchanged and doutA holds its last value over several cycles despite address changes.

Source files
------------

// File: rtl/iob_ram_tdp_be_sync_if.sv
`default_nettype none
// ============================================================================
//  Module   : iob_ram_tdp_be_sync_if
//  Purpose  : Bundles both access ports (A and B) of the true dual-port,
//             byte-enabled RAM.
//  Ports    : enX   - port X access enable
//             weX   - port X byte write enables (bit k -> din[8k+7:8k])
//             addrX - port X word address
//             dinX  - port X write data
//             doutX - port X registered read data
//  Modports : master - drives the requests and receives the read data
//             slave  - the RAM side
//  Revision : 1.0 - initial release
// ============================================================================
interface iob_ram_tdp_be_sync_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic                  enA;
  logic [DATA_W/8-1:0]   weA;
  logic [ADDR_W-1:0]     addrA;
  logic [DATA_W-1:0]     dinA;
  logic [DATA_W-1:0]     doutA;

  logic                  enB;
  logic [DATA_W/8-1:0]   weB;
  logic [ADDR_W-1:0]     addrB;
  logic [DATA_W-1:0]     dinB;
  logic [DATA_W-1:0]     doutB;

  modport master (
    output enA, weA, addrA, dinA,
    output enB, weB, addrB, dinB,
    input  doutA, doutB
  );

  modport slave (
    input  enA, weA, addrA, dinA,
    input  enB, weB, addrB, dinB,
    output doutA, doutB
  );
endinterface
`default_nettype wire

// File: rtl/iob_ram_tdp_be_sync.sv
`default_nettype none
// ============================================================================
//  Module   : iob_ram_tdp_be_sync
//  Purpose  : True dual-port RAM, single clock, per-byte write enables,
//             read-first registered outputs with synchronous reset.
//  Ports    : clk - system clock, all activity on rising edge
//             rst - synchronous active-high reset (clears read data only)
//             bus - iob_ram_tdp_be_sync_if.slave carrying ports A and B
//  Revision : 1.0 - initial release
// ============================================================================
module iob_ram_tdp_be_sync #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  wire logic              clk,
  input  wire logic              rst,
  iob_ram_tdp_be_sync_if.slave   bus
);
  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [DATA_W-1:0] dout_a_d, dout_a_q;
  logic [DATA_W-1:0] dout_b_d, dout_b_q;

  // Read data sampled from the array before this edge's writes land,
  // which gives read-first behaviour on both ports.
  always_comb begin
    dout_a_d = dout_a_q;
    dout_b_d = dout_b_q;
    if (bus.enA) dout_a_d = mem_q[bus.addrA];
    if (bus.enB) dout_b_d = mem_q[bus.addrB];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_a_q <= '0;
      dout_b_q <= '0;
    end else begin
      dout_a_q <= dout_a_d;
      dout_b_q <= dout_b_d;
    end
  end

  // Byte writes. Port B is applied first so that, on a same-address,
  // same-lane collision, port A's later non-blocking assignment wins.
  // Enable is tested before the byte strobe so unknown strobes on an idle
  // port cannot reach the array.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NB; k++) begin
        if (bus.enB && bus.weB[k]) mem_q[bus.addrB][8*k +: 8] <= bus.dinB[8*k +: 8];
      end
      for (int k = 0; k < NB; k++) begin
        if (bus.enA && bus.weA[k]) mem_q[bus.addrA][8*k +: 8] <= bus.dinA[8*k +: 8];
      end
    end
  end

  assign bus.doutA = dout_a_q;
  assign bus.doutB = dout_b_q;

endmodule
`default_nettype wire

// File: tb/tb_iob_ram_tdp_be_sync.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iob_ram_tdp_be_sync
//  Purpose  : Self-checking bench for iob_ram_tdp_be_sync. A reference memory
//             produces expected read data, which is queued when a cycle is
//             driven and popped after the clock edge for comparison.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_iob_ram_tdp_be_sync;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iob_ram_tdp_be_sync_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  iob_ram_tdp_be_sync #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [31:0] model [16];
  logic [31:0] last_a = '0;
  logic [31:0] last_b = '0;
  logic [31:0] q_a [$];
  logic [31:0] q_b [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] we,
                                        input logic [31:0] din);
    logic [31:0] r = old;
    for (int k = 0; k < 4; k++) if (we[k]) r[8*k +: 8] = din[8*k +: 8];
    return r;
  endfunction

  // One clock cycle on both ports. Expected read data comes from the model
  // before it is updated (read-first); B updates before A so A wins lanes.
  task automatic step(input logic ea, input logic [3:0] wa, input logic [3:0] aa,
                      input logic [31:0] da,
                      input logic eb, input logic [3:0] wb, input logic [3:0] ab,
                      input logic [31:0] db,
                      input bit chk_a, input bit chk_b, input string tag);
    logic [31:0] ea_exp, eb_exp;
    bus.enA = ea; bus.weA = wa; bus.addrA = aa; bus.dinA = da;
    bus.enB = eb; bus.weB = wb; bus.addrB = ab; bus.dinB = db;
    ea_exp = ea ? model[aa] : last_a;
    eb_exp = eb ? model[ab] : last_b;
    if (chk_a) q_a.push_back(ea_exp);
    if (chk_b) q_b.push_back(eb_exp);
    last_a = ea_exp;
    last_b = eb_exp;
    if (eb) model[ab] = merge(model[ab], wb, db);
    if (ea) model[aa] = merge(model[aa], wa, da);
    @(posedge clk);
    #1;
    if (chk_a) check({tag, "_A"}, bus.doutA, q_a.pop_front());
    if (chk_b) check({tag, "_B"}, bus.doutB, q_b.pop_front());
  endtask

  task automatic idle_cycle(input string tag);
    step(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b1, tag);
  endtask

  task automatic reset_cycle();
    rst = 1'b1;
    bus.enA = 1'b1; bus.weA = 4'hF; bus.addrA = 4'd9; bus.dinA = 32'hFFFF_FFFF;
    bus.enB = 1'b1; bus.weB = 4'hF; bus.addrB = 4'd9; bus.dinB = 32'hEEEE_EEEE;
    q_a.push_back(32'h0);
    q_b.push_back(32'h0);
    last_a = '0;
    last_b = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_doutA", bus.doutA, q_a.pop_front());
    check("reset_doutB", bus.doutB, q_b.pop_front());
  endtask

  initial begin
    for (int i = 0; i < 16; i++) model[i] = 'x;
    reset_cycle();
    idle_cycle("idle_after_reset");

    // Port A fill, then readback through A.
    for (int i = 0; i < 16; i++)
      step(1'b1, 4'hF, 4'(i), 32'(32 + i), 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0, "fillA");
    for (int i = 0; i < 16; i++)
      step(1'b1, 4'h0, 4'(i), 32'h0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0, "readA");

    // Port B overwrite (read-first returns A's data), then read on both ports.
    for (int i = 0; i < 16; i++)
      step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'hF, 4'(i), 32'(64 + i), 1'b0, 1'b1, "writeB");
    for (int i = 0; i < 16; i++)
      step(1'b1, 4'h0, 4'(i), 32'h0, 1'b1, 4'h0, 4'(i), 32'h0, 1'b1, 1'b1, "readAB");
    check("readAB_last_const", bus.doutA, 32'd79);

    // Byte enables on address 3.
    step(1'b1, 4'hF, 4'd3, 32'hAABB_CCDD, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0, "be_full");
    step(1'b1, 4'b0010, 4'd3, 32'h1122_3344, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0, "be_lane1");
    step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h0, 4'd3, 32'h0, 1'b0, 1'b1, "be_rd1");
    check("be_rd1_const", bus.doutB, 32'hAABB_33DD);
    step(1'b1, 4'b1001, 4'd3, 32'h5566_7788, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0, "be_lane30");
    step(1'b1, 4'h0, 4'd3, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0, "be_rd2");
    check("be_rd2_const", bus.doutA, 32'h55BB_3388);

    // Read-first collision: A writes addr 5 while B reads it.
    step(1'b1, 4'hF, 4'd5, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0, "clr5");
    step(1'b1, 4'hF, 4'd5, 32'h1234_5678, 1'b1, 4'h0, 4'd5, 32'h0, 1'b1, 1'b1, "coll_rf");
    check("coll_rf_constB", bus.doutB, 32'h0);
    step(1'b1, 4'h0, 4'd5, 32'h0, 1'b1, 4'h0, 4'd5, 32'h0, 1'b1, 1'b1, "coll_rd");
    check("coll_rd_constB", bus.doutB, 32'h1234_5678);

    // Both ports write addr 6 full word: A wins.
    step(1'b1, 4'hF, 4'd6, 32'h1, 1'b1, 4'hF, 4'd6, 32'h2, 1'b0, 1'b0, "ww6");
    step(1'b1, 4'h0, 4'd6, 32'h0, 1'b1, 4'h0, 4'd6, 32'h0, 1'b1, 1'b1, "ww6_rd");
    check("ww6_const", bus.doutA, 32'h1);

    // Different lanes on the same address merge: A lane 0, B lane 3.
    step(1'b1, 4'b0001, 4'd8, 32'h0000_00A1, 1'b1, 4'b1000, 4'd8, 32'hB200_0000,
         1'b0, 1'b0, "merge8");
    step(1'b1, 4'h0, 4'd8, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0, "merge8_rd");
    check("merge8_const", bus.doutA, 32'hB200_00A1 | (32'd72 & 32'h00FF_FF00));

    // Enable gating: A reads 7, then is idle with strobes and data set.
    step(1'b1, 4'h0, 4'd7, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0, "gate_pre");
    for (int i = 0; i < 4; i++)
      step(1'b0, (i == 0) ? 4'hF : 4'bxxxx, 4'(2 + i), 32'hDEAD_BEEF, 1'b0, 4'h0, 4'h0,
           32'h0, 1'b1, 1'b1, "gate_hold");
    check("gate_hold_const", bus.doutA, 32'd71);
    step(1'b1, 4'h0, 4'd2, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0, "gate_rd2");
    check("gate_rd2_const", bus.doutA, 32'd66);

    // Mid-run reset with both ports enabled and writing addr 9: no write lands.
    reset_cycle();
    step(1'b1, 4'h0, 4'd9, 32'h0, 1'b1, 4'h0, 4'd9, 32'h0, 1'b1, 1'b1, "post_rst_rd9");
    check("post_rst_rd9_const", bus.doutB, 32'd73);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, observed running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
